pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage datapath (IF/ID/EX/MEM/WB).
- Detects load-use hazards in ID and inserts one bubble into ID/EX.
- Squashes IF/ID and ID/EX on a taken branch resolved in EX.
- Sequences the multi-cycle multiplier occupying EX.
- Freezes the pipeline while the data memory reports busy.
- Sits beside the forwarding unit and drives the write-enables and flushes of the pipeline registers and PC.

## Interface
- MUL_CYCLES, 4, EX occupancy of a multiply in cycles (1..15).
- RW, 4, register-address width.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  RW  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt.
- id_mul  in  1  ID instruction is a multiply.
- ex_rd  in  RW  destination register of the instruction in EX.
- ex_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_busy  in  1  MEM-stage access not complete this cycle.
- pc_we, ifid_we  out  1  PC / IF-ID register write enables.
- ifid_flush, idex_bubble  out  1  load NOP into IF/ID / ID/EX.
- ex_hold, mem_hold  out  1  hold EX/MEM / MEM/WB registers.
- mul_start  out  1  one-cycle multiplier launch pulse.
- state  out  2  RUN=0, MULBUSY=1, MEMWAIT=2.

## Operation
- Registered state: `state[1:0]`, `mcnt[3:0]`, `ret_mul` (MEMWAIT return target).
- Outputs are Mealy: a function of the registered state and the current inputs.
- Defaults: pc_we=1, ifid_we=1, all other outputs 0.
- Load-use hazard `lu` = ex_load & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- RUN, evaluated in priority order:
  1. mem_busy: pc_we=ifid_we=0, ex_hold=mem_hold=1. Next state MEMWAIT, ret_mul=0.
  2. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_we=1 (PC takes the branch target). Stay in RUN; `lu` and id_mul are ignored because the ID instruction is squashed.
  3. lu: pc_we=ifid_we=0, idex_bubble=1. Stay in RUN; the hazard clears the next cycle once the load reaches MEM.
  4. id_mul: mul_start=1; the multiply advances into EX at this edge.
     - If MUL_CYCLES>1: next state MULBUSY, mcnt=MUL_CYCLES-2.
     - If MUL_CYCLES=1: stay in RUN.
- MULBUSY: pc_we=ifid_we=0, ex_hold=1.
  - MEM/WB keep advancing; the bubble in EX/MEM is handled by the datapath via ex_hold.
  - If mem_busy: also mem_hold=1, next state MEMWAIT, ret_mul=1, mcnt frozen.
  - Else if mcnt==0: next state RUN.
  - Else mcnt decrements.
  - ex_branch_taken, lu and id_mul are ignored, because EX holds the multiply.
- MEMWAIT:
  - While mem_busy=1: pc_we=ifid_we=0, ex_hold=mem_hold=1.
  - In the cycle mem_busy=0, outputs and next state are exactly those of the return state (RUN or MULBUSY) evaluated with the current inputs. mcnt resumes from its frozen value.
- mcnt arithmetic is unsigned 4-bit. It never wraps, because decrement occurs only when mcnt>0.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, mcnt=0, ret_mul=0.
  - Outputs then follow RUN decoding of the inputs; with idle inputs they are pc_we=ifid_we=1, all others 0.
- Reset asserted mid-MULBUSY or mid-MEMWAIT aborts immediately, with no pending mul_start.
- Load-use stall costs exactly one cycle.
- Branch penalty: two squashed instructions (IF/ID and ID/EX) in the same cycle.
- Multiply: EX is occupied MUL_CYCLES cycles total (the issue cycle plus MUL_CYCLES-1 in MULBUSY), excluding MEMWAIT cycles.
- mul_start is never asserted two consecutive cycles.
- mem_busy and ex_branch_taken together: the memory stall wins, and the branch is re-evaluated when mem_busy drops because EX is held.
- lu and id_mul together: lu wins; the multiply issues on the following cycle.

## Configuration
- HAZ_R0_EXEMPT_EN defined: register 0 is hardwired zero, so `lu` is forced to 0 whenever ex_rd==0.
- HAZ_R0_EXEMPT_EN undefined: register 0 is treated like any other register.

## Test plan
- Load-use: ex_load=1, ex_rd=3, id_rs=3, id_use_rs=1 -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1, then pc_we=1.
- Branch priority: ex_branch_taken=1 together with the load-use condition -> ifid_flush=1, idex_bubble=1, pc_we=1, no stall.
- Multiply, MUL_CYCLES=4: id_mul=1 -> mul_start for 1 cycle, state=1 for 3 cycles with ex_hold=1, then back to RUN.
- Memory stall mid-multiply: mem_busy=1 for 2 cycles while mcnt=1 -> state=2 with mem_hold=1 for 2 cycles, then MULBUSY resumes with mcnt=1, and the total multiply occupancy is 4+2 cycles.
- R0 exemption: ex_load=1, ex_rd=0, id_rs=0 -> no stall with HAZ_R0_EXEMPT_EN; a 1-cycle stall without it.
- Async reset: drop rst_n in MULBUSY with mcnt=2 -> state=0 immediately without waiting for a clock edge, no mul_start after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// multi-cycle multiply occupancy of EX and data-memory freeze. Option: HAZ_R0_EXEMPT_EN.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int RW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_mul,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_load,
    input  logic          ex_branch_taken,
    input  logic          mem_busy,
    output logic          pc_we,
    output logic          ifid_we,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic          ex_hold,
    output logic          mem_hold,
    output logic          mul_start,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MULBUSY = 2'd1,
        S_MEMWAIT = 2'd2
    } state_e;

    localparam logic [3:0] MCNT_INIT = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;
    localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

    state_e     state_q, state_d;
    logic [3:0] mcnt_q, mcnt_d;
    logic       ret_mul_q, ret_mul_d;

    logic lu_raw, lu;
    logic do_run, do_mul;

    assign lu_raw = ex_load & ((id_use_rs & (id_rs == ex_rd)) |
                               (id_use_rt & (id_rt == ex_rd)));
`ifdef HAZ_R0_EXEMPT_EN
    assign lu = lu_raw & (ex_rd != '0);
`else
    assign lu = lu_raw;
`endif

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mem_hold    = 1'b0;
        mul_start   = 1'b0;
        state_d     = state_q;
        mcnt_d      = mcnt_q;
        ret_mul_d   = ret_mul_q;
        do_run      = 1'b0;
        do_mul      = 1'b0;

        case (state_q)
            S_RUN:     do_run = 1'b1;
            S_MULBUSY: do_mul = 1'b1;
            S_MEMWAIT: begin
                if (mem_busy) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    ex_hold  = 1'b1;
                    mem_hold = 1'b1;
                end else begin
                    // memory released: behave exactly as the state we froze out of
                    do_run = ~ret_mul_q;
                    do_mul = ret_mul_q;
                end
            end
            default:   state_d = S_RUN;
        endcase

        if (do_run) begin
            state_d = S_RUN;
            if (mem_busy) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                ex_hold   = 1'b1;
                mem_hold  = 1'b1;
                state_d   = S_MEMWAIT;
                ret_mul_d = 1'b0;
            end else if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_mul) begin
                mul_start = 1'b1;
                if (MUL_MULTI) begin
                    state_d = S_MULBUSY;
                    mcnt_d  = MCNT_INIT;
                end
            end
        end

        if (do_mul) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            ex_hold = 1'b1;
            if (mem_busy) begin
                mem_hold  = 1'b1;
                state_d   = S_MEMWAIT;
                ret_mul_d = 1'b1;
            end else if (mcnt_q == 4'd0) begin
                state_d = S_RUN;
            end else begin
                state_d = S_MULBUSY;
                mcnt_d  = mcnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            mcnt_q    <= 4'd0;
            ret_mul_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcnt_q    <= mcnt_d;
            ret_mul_q <= ret_mul_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MUL_CYCLES=4); expected output words are queued
// when a step is driven and popped when the outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, id_mul, ex_load, ex_branch_taken, mem_busy;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mem_hold, mul_start;
    logic [1:0] state;

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mul(id_mul), .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .ex_hold(ex_hold), .mem_hold(mem_hold),
        .mul_start(mul_start), .state(state)
    );

    always #5 clk = ~clk;

    // {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mem_hold, mul_start, state[1:0]}
    logic [8:0] obs;
    assign obs = {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mem_hold, mul_start, state};

    localparam logic [8:0] IDLE    = 9'b1_1_0_0_0_0_0_00;
    localparam logic [8:0] LU_STL  = 9'b0_0_0_1_0_0_0_00;
    localparam logic [8:0] BRANCH  = 9'b1_1_1_1_0_0_0_00;
    localparam logic [8:0] MSTART  = 9'b1_1_0_0_0_0_1_00;
    localparam logic [8:0] MBUSY   = 9'b0_0_0_0_1_0_0_01;
    localparam logic [8:0] MBUSY_M = 9'b0_0_0_0_1_1_0_01;
    localparam logic [8:0] RUN_M   = 9'b0_0_0_0_1_1_0_00;
    localparam logic [8:0] MW_BUSY = 9'b0_0_0_0_1_1_0_10;
    localparam logic [8:0] MW_MUL  = 9'b0_0_0_0_1_0_0_10;
    localparam logic [8:0] MW_BR   = 9'b1_1_1_1_0_0_0_10;

    logic [8:0] sb_q[$];
    int total = 0;
    int fails = 0;

    task automatic idle_inputs();
        id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_mul = 1'b0;
        ex_load = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic compare(input string tag, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // inputs are already driven for this cycle; sample mid-cycle, then step past the edge
    task automatic step(input string tag, input logic [8:0] exp);
        logic [8:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        e = sb_q.pop_front();
        compare(tag, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        compare("reset_idle", IDLE);
        ex_load = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_use_rs = 1'b1;
        #1;
        compare("reset_run_decode", LU_STL);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("idle", IDLE);

        ex_load = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_use_rs = 1'b1;
        step("lu_rs_stall", LU_STL);
        ex_load = 1'b0;
        step("lu_released", IDLE);

        ex_load = 1'b1; ex_branch_taken = 1'b1;
        step("branch_over_lu", BRANCH);
        ex_branch_taken = 1'b0;

        id_use_rs = 1'b0; id_rt = 4'd5; ex_rd = 4'd5; id_use_rt = 1'b1;
        step("lu_rt_stall", LU_STL);
        id_use_rt = 1'b0;
        step("rt_match_unused", IDLE);
        id_use_rt = 1'b1; ex_rd = 4'd6;
        step("rt_no_match", IDLE);

        ex_rd = 4'd5; id_mul = 1'b1;
        step("lu_over_mul", LU_STL);
        ex_load = 1'b0;
        step("mul_start", MSTART);
        step("mulbusy_2", MBUSY);
        ex_branch_taken = 1'b1; ex_load = 1'b1;
        step("mulbusy_1_ign", MBUSY);
        ex_branch_taken = 1'b0; ex_load = 1'b0;
        step("mulbusy_0", MBUSY);
        id_mul = 1'b0;
        step("mul_done", IDLE);

        idle_inputs();
        id_mul = 1'b1;
        step("mul2_start", MSTART);
        id_mul = 1'b0;
        step("mul2_busy_2", MBUSY);
        mem_busy = 1'b1;
        step("mul2_busy_1_mem", MBUSY_M);
        step("mul2_memwait", MW_BUSY);
        mem_busy = 1'b0;
        step("mul2_mw_release", MW_MUL);
        step("mul2_busy_0", MBUSY);
        step("mul2_done", IDLE);

        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        step("mem_over_branch", RUN_M);
        mem_busy = 1'b0;
        step("branch_after_mw", MW_BR);
        ex_branch_taken = 1'b0;
        step("post_branch_idle", IDLE);

        ex_load = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_use_rs = 1'b1;
`ifdef HAZ_R0_EXEMPT_EN
        step("r0_exempt", IDLE);
`else
        step("r0_stall", LU_STL);
`endif
        idle_inputs();
        step("r0_after", IDLE);

        id_mul = 1'b1;
        step("mul3_start", MSTART);
        id_mul = 1'b0;
        #2;
        compare("mul3_busy_2", MBUSY);
        rst_n = 1'b0;
        #1;
        compare("async_reset_abort", IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset_1", IDLE);
        step("post_reset_2", IDLE);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
